// File: rtl/seg_push_arbiter_if.sv
// Requester handshakes plus display-side outputs of seg_push_arbiter.
interface seg_push_arbiter_if #(
    parameter int NIBBLES = 6
) ();
    // Handshake: a requester drives reqN_valid with reqN_data held stable; the value
    // is taken on the rising clk edge where reqN_valid && reqN_ready are both high.
    logic                 req0_valid;
    logic [4*NIBBLES-1:0] req0_data;
    logic                 req0_ready;
    logic                 req1_valid;
    logic [4*NIBBLES-1:0] req1_data;
    logic                 req1_ready;
    logic [4:0]           disp_out;
    logic                 busy;
    logic                 owner;
    logic [1:0]           dbg_state;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, disp_out, busy, owner, dbg_state
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, disp_out, busy, owner, dbg_state
    );
endinterface

// File: rtl/seg_push_arbiter.sv
// Two-requester arbiter feeding a shift-in seven-segment display, MS nibble first.
// SEG_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins ties) instead of round-robin.
module seg_push_arbiter #(
    parameter int NIBBLES = 6,
    parameter int GAP     = 0
) (
    input logic               clk,
    input logic               rst,
    seg_push_arbiter_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);
    localparam logic [3:0]    GAP_LAST = 4'(GAP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  buf_q, buf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    gap_q, gap_d;
    logic          done_q, done_d;
    logic          last_grant_q, last_grant_d;
    logic          owner_q, owner_d;
    logic [4:0]    disp_q, disp_d;
    logic [3:0]    nib_d;
    logic          grant0, grant1;
    logic          ready0, ready1;

    always_comb begin
`ifdef SEG_ARB_FIXED_PRIO_EN
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid && !bus.req0_valid;
`else
        grant0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
        grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
`endif
    end

    // Ready is masked while rst is high so nothing is accepted on a reset edge.
    assign ready0 = (state_q == IDLE) && !rst && grant0;
    assign ready1 = (state_q == IDLE) && !rst && grant1;

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        done_d       = done_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        unique case (state_q)
            IDLE: begin
                if (ready0 || ready1) begin
                    buf_d        = ready1 ? bus.req1_data : bus.req0_data;
                    owner_d      = ready1;
                    last_grant_d = ready1;
                    cnt_d        = '0;
                    done_d       = 1'b0;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                gap_d = '0;
                if (cnt_q == LAST_CNT) begin
                    done_d  = 1'b1;
                    state_d = (GAP == 0) ? IDLE : WAIT;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (GAP == 0) ? SHIFT : WAIT;
                end
            end
            WAIT: begin
                if (gap_q == GAP_LAST) begin
                    state_d = done_q ? IDLE : SHIFT;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The output register is loaded from the next state, so a strobe is visible
        // in exactly the cycles the FSM spends in SHIFT.
        nib_d = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt_d == CW'(NIBBLES - 1 - i)) nib_d = buf_d[4*i +: 4];
        end
        disp_d = (state_d == SHIFT) ? {1'b1, nib_d} : 5'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            cnt_q        <= '0;
            gap_q        <= '0;
            done_q       <= 1'b0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            disp_q       <= 5'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            done_q       <= done_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            disp_q       <= disp_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.disp_out   = disp_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.owner      = owner_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_seg_push_arbiter.sv
// Randomised scoreboard bench for seg_push_arbiter: one instance with GAP=0, one with GAP=2.
module tb_seg_push_arbiter;
    localparam int N       = 6;
    localparam int W       = 4 * N;
    localparam int END_CYC = 1100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_v  [2];
    logic         vld    [2][2];
    logic [W-1:0] dat    [2][2];
    logic         rdy    [2][2];
    logic [4:0]   dout   [2];
    logic         busy_s [2];
    logic         own_s  [2];

    seg_push_arbiter_if #(.NIBBLES(N)) if0 ();
    seg_push_arbiter_if #(.NIBBLES(N)) if1 ();

    seg_push_arbiter #(.NIBBLES(N), .GAP(0)) dut0 (.clk(clk), .rst(rst_v[0]), .bus(if0.slave));
    seg_push_arbiter #(.NIBBLES(N), .GAP(2)) dut1 (.clk(clk), .rst(rst_v[1]), .bus(if1.slave));

    assign if0.req0_valid = vld[0][0];
    assign if0.req0_data  = dat[0][0];
    assign if0.req1_valid = vld[0][1];
    assign if0.req1_data  = dat[0][1];
    assign if1.req0_valid = vld[1][0];
    assign if1.req0_data  = dat[1][0];
    assign if1.req1_valid = vld[1][1];
    assign if1.req1_data  = dat[1][1];
    assign rdy[0][0] = if0.req0_ready;
    assign rdy[0][1] = if0.req1_ready;
    assign rdy[1][0] = if1.req0_ready;
    assign rdy[1][1] = if1.req1_ready;
    assign dout[0]   = if0.disp_out;
    assign dout[1]   = if1.disp_out;
    assign busy_s[0] = if0.busy;
    assign busy_s[1] = if1.busy;
    assign own_s[0]  = if0.owner;
    assign own_s[1]  = if1.owner;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    // Scoreboard entry: {last_nibble, cycle[31:0], disp_out[4:0]}
    logic [37:0]  exp_q   [2][$];
    logic [W-1:0] exp_dat [2][$];
    logic [W-1:0] shadow  [2];

    // Reference model state: last busy cycle, last granted id, current owner
    int   m_end   [2];
    logic m_last  [2];
    logic m_owner [2];

    logic [W-1:0] sq [4][$];   // pending values per requester, index d*2+r
    int rst_at   [2];
    int pulse_at [2];

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d actual=%0h required=%0h", name, d, cyc, act, req);
        end
    endtask

    // ---------------- reference model: grants, ready/busy/owner, strobe schedule
    logic mb_busy, mb_win, mb_r0, mb_r1;
    int   mb_g;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            mb_g    = gap_of(d);
            mb_busy = (cyc <= m_end[d]);
`ifdef SEG_ARB_FIXED_PRIO_EN
            mb_win = !vld[d][0];
`else
            mb_win = (vld[d][0] && vld[d][1]) ? !m_last[d] : !vld[d][0];
`endif
            mb_r0 = !rst_v[d] && !mb_busy && vld[d][0] && !mb_win;
            mb_r1 = !rst_v[d] && !mb_busy && vld[d][1] && mb_win;
            if (cyc >= 1) begin
                check("req0_ready", d, 32'(rdy[d][0]), 32'(mb_r0));
                check("req1_ready", d, 32'(rdy[d][1]), 32'(mb_r1));
                check("busy", d, 32'(busy_s[d]), 32'(mb_busy));
                check("owner", d, 32'(own_s[d]), 32'(m_owner[d]));
            end
            if (rst_v[d]) begin
                m_end[d]   = cyc;
                m_last[d]  = 1'b1;
                m_owner[d] = 1'b0;
                for (int k = exp_q[d].size() - 1; k >= 0; k--) begin
                    if (int'(exp_q[d][k][36:5]) > cyc) begin
                        if (exp_q[d][k][37]) void'(exp_dat[d].pop_back());
                        exp_q[d].delete(k);
                    end
                end
            end else if (mb_r0 || mb_r1) begin
                for (int j = 0; j < N; j++) begin
                    exp_q[d].push_back({(j == N - 1), 32'(cyc + 1 + j * (1 + mb_g)),
                                        1'b1, dat[d][int'(mb_win)][4*(N-1-j) +: 4]});
                end
                exp_dat[d].push_back(dat[d][int'(mb_win)]);
                m_end[d]   = cyc + N * (1 + mb_g);
                m_last[d]  = mb_win;
                m_owner[d] = mb_win;
            end
        end
    end

    // ---------------- monitor: pops the scoreboard whenever a strobe appears
    logic [37:0] mon_e;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (cyc >= 1) begin
                while (exp_q[d].size() > 0 && int'(exp_q[d][0][36:5]) < cyc) begin
                    mon_e = exp_q[d].pop_front();
                    if (mon_e[37]) void'(exp_dat[d].pop_front());
                    checks++;
                    failures++;
                    $display("FAIL missed_strobe dut%0d cyc=%0d actual=none required=%0h at cyc %0d",
                             d, cyc, mon_e[4:0], int'(mon_e[36:5]));
                end
                if (dout[d][4]) begin
                    shadow[d] = {shadow[d][W-5:0], dout[d][3:0]};
                    if (exp_q[d].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_strobe dut%0d cyc=%0d actual=%0h required=no strobe",
                                 d, cyc, dout[d]);
                    end else if (int'(exp_q[d][0][36:5]) != cyc) begin
                        check("strobe_cycle", d, 32'(cyc), exp_q[d][0][36:5]);
                    end else begin
                        mon_e = exp_q[d].pop_front();
                        check("strobe_value", d, 32'(dout[d]), 32'(mon_e[4:0]));
                        if (mon_e[37]) check("display_reg", d, 32'(shadow[d]), 32'(exp_dat[d].pop_front()));
                    end
                end else begin
                    check("idle_disp", d, 32'(dout[d]), 32'd0);
                end
            end
        end
    end

    // ---------------- stimulus / requester drivers
    logic hs [2][2];
    logic gl [2][2];
    int   qi;
    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_v[d]    = 1'b1;
            m_end[d]    = -1;
            m_last[d]   = 1'b1;
            m_owner[d]  = 1'b0;
            shadow[d]   = '0;
            rst_at[d]   = -1;
            pulse_at[d] = -1;
            for (int r = 0; r < 2; r++) begin
                vld[d][r] = 1'b0;
                dat[d][r] = '0;
                hs[d][r]  = 1'b0;
                gl[d][r]  = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        while (cyc < END_CYC) begin
            for (int d = 0; d < 2; d++) begin
                for (int r = 0; r < 2; r++) begin
                    qi = d * 2 + r;
                    if (hs[d][r] && !gl[d][r] && sq[qi].size() > 0) void'(sq[qi].pop_front());
                end
                if (cyc == 2) begin
                    sq[d*2].push_back(24'h123456);
                    sq[d*2+1].push_back(24'h0F0F0F);
                end
                if (cyc == 60) begin
                    repeat (3) begin
                        sq[d*2].push_back(24'hAAAAAA);
                        sq[d*2+1].push_back(24'h555555);
                    end
                end
                if (cyc == 200) sq[d*2].push_back(24'h987654);
                if (cyc == 260) begin
                    sq[d*2].push_back(24'hABCDEF);
                    sq[d*2+1].push_back(24'hFEDCBA);
                end
                if (cyc == 310) sq[d*2].push_back(24'h13579B);
                rst_v[d] = (cyc < 2) || (cyc == rst_at[d]) ||
                           (cyc >= 360 && cyc < 950 && $urandom_range(0, 299) == 0);
                for (int r = 0; r < 2; r++) begin
                    qi = d * 2 + r;
                    if (cyc >= 360 && cyc < 950 && sq[qi].size() == 0 && $urandom_range(0, 5) == 0)
                        sq[qi].push_back(W'($urandom));
                    gl[d][r] = 1'b0;
                    if (r == 1 && cyc == pulse_at[d]) begin
                        gl[d][r]  = 1'b1;
                        dat[d][r] = 24'hDEAD00;
                    end else if (cyc >= 360 && cyc < 950 && sq[qi].size() == 0 &&
                                 $urandom_range(0, 15) == 0) begin
                        gl[d][r]  = 1'b1;
                        dat[d][r] = W'($urandom);
                    end else if (sq[qi].size() > 0) begin
                        dat[d][r] = sq[qi][0];
                    end
                    vld[d][r] = (cyc < 2) || gl[d][r] || (sq[qi].size() > 0);
                end
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int r = 0; r < 2; r++) hs[d][r] = vld[d][r] && rdy[d][r];
                if (hs[d][0] && dat[d][0] == 24'h987654 && cyc >= 200 && cyc < 260)
                    rst_at[d] = cyc + 2 + 2 * (1 + gap_of(d));
                if (hs[d][0] && dat[d][0] == 24'h13579B && cyc >= 310 && cyc < 360)
                    pulse_at[d] = cyc + 2;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        for (int d = 0; d < 2; d++) check("scoreboard_drained", d, 32'(exp_q[d].size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_push_arbiter.md
Name: seg_push_arbiter

Overview:
- Shares the six-digit shift-in seven-segment display between two requesters, for example a CPU register port and a keypad/scan source.
- Each requester hands over a full 24-bit display value with a valid/ready handshake. The block arbitrates between requesters, captures the winning value and serialises it.
- Output is the display's 5-bit input: bit 4 is the shift strobe, bits 3:0 are the nibble.
- Nibbles are pushed most-significant first, so the display register equals the submitted value after the last strobe.

Parameters:
- NIBBLES, 6: digits per transfer. Value width is 4*NIBBLES.
- GAP, 0: idle cycles inserted after each strobe (0..15).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- req0_valid  input  1  requester 0 has a value
- req0_data  input  4*NIBBLES  requester 0 display value
- req0_ready  output  1  requester 0 value accepted this cycle
- req1_valid  input  1  requester 1 has a value
- req1_data  input  4*NIBBLES  requester 1 display value
- req1_ready  output  1  requester 1 value accepted this cycle
- disp_out  output  5  {strobe, nibble} to the display input
- busy  output  1  transfer in progress
- owner  output  1  requester currently being served (valid while busy)

Behaviour:
- Reset: state IDLE, disp_out=5'b0, busy=0, owner=0, last_grant=1 (so req0 wins the first tie), nibble counter=0, gap counter=0.
- States:
  - IDLE:
    - grant is combinational from the valid inputs and last_grant.
    - reqN_ready = (state==IDLE) && grantN. It is never high for both requesters, and never high outside IDLE.
    - On valid&&ready: capture the data into a buffer, set owner and last_grant to the granted id, clear the nibble counter, go to SHIFT.
  - SHIFT:
    - disp_out (registered) = {1'b1, buf[4*(NIBBLES-1-cnt) +: 4]}; cnt increments.
    - After the strobe with cnt==NIBBLES-1: go to IDLE if GAP==0, else WAIT.
    - Otherwise go to WAIT if GAP>0, else stay in SHIFT.
  - WAIT:
    - disp_out=5'b0 for GAP cycles, then SHIFT.
    - If the last nibble has already been sent, go to IDLE instead.
- Strobe timing: the first strobe is visible the cycle after the accepting edge. disp_out is 5'b0 in every non-strobe cycle, so the strobe is exactly one cycle wide.
- A transfer occupies NIBBLES*(1+GAP) cycles after acceptance. The next acceptance can happen in the first IDLE cycle after that.
- Round-robin: if only one valid, grant it. If both valid, grant the one not equal to last_grant.
- Requesters must hold valid and data stable until ready. A valid dropped before ready is simply not served. Data is sampled only on the accepting edge; changes after acceptance do not affect the transfer in flight.
- busy=1 in SHIFT and WAIT. owner holds the served id while busy and retains it in IDLE.
- Reset mid-transfer:
  - Next cycle disp_out=0 and state IDLE. The remaining nibbles are discarded.
  - The display keeps the partially shifted contents.
  - last_grant returns to 1.
- Counter widths: cnt is ceil(log2(NIBBLES)) bits, gap counter is 4 bits. Neither wraps within a transfer.

Optional Feature:
- SEG_ARB_FIXED_PRIO_EN defined: fixed priority. req0 always wins when both are valid, and last_grant is ignored. Without it: round-robin as above.

Test Plan:
1. Reset: assert rst for 2 cycles with both valids high. Required: disp_out=0, busy=0, both readys 0 during reset. req0_ready=1 in the first cycle after reset.
2. Single push (GAP=0): req0 sends 24'h123456. Required: req0_ready high for exactly 1 cycle. Next 6 cycles disp_out = 5'h11, 12, 13, 14, 15, 16, then 5'h00 and busy=0. Displayed register = 24'h123456.
3. Contention: both valid continuously, req0=24'hAAAAAA, req1=24'h555555. Required grant order req0, req1, req0, req1. Each transfer is 6 strobes, and the next ready comes on the first IDLE cycle. With SEG_ARB_FIXED_PRIO_EN, req0 is served repeatedly.
4. Gap timing (GAP=2): req1 sends 24'h0F0F0F. Required strobes at cycles 1, 4, 7, 10, 13, 16 after acceptance, nibbles 0,F,0,F,0,F, disp_out=0 between strobes. busy stays high through cycle 18.
5. Reset mid-operation: assert rst after the 3rd strobe of 24'h987654. Required: no further strobes, busy=0 next cycle. The next tied request goes to req0.
6. Hold violation: req1_valid pulses for 1 cycle while busy. Required: it is never accepted, and req1_ready stays 0 throughout.
